pipeline_lock_controller: RTL and testbench

// - Central stall/flush sequencer for the 5-stage pipeline; drives the lock input of every

---
 rtl/pipeline_lock_controller.sv | 166 ++++++++++++++++
 tb/tb_pipeline_lock_controller.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_lock_controller.sv
// pipeline_lock_controller
//   Central stall/flush sequencer for the 5-stage pipeline. It drives the hold
//   input of every stage buffer and of the PC. It serialises multi-cycle cache
//   misses, inserts load-use bubbles, flushes the younger stages on a taken
//   redirect, and freezes the pipe after a halt.
//
//   Optional feature: define PIPE_STALL_STATS_EN to add the stall_cycles and
//   flush_count statistics outputs.
//
// Ports
//   clk                    in   rising-edge clock
//   rst_b                  in   asynchronous reset, active-high (1 = reset)
//   mem_access_mem         in   MEM-stage instruction is a load/store
//   cache_hit_mem          in   cache hit for the MEM-stage access
//   is_nop_mem             in   MEM-stage slot is a bubble
//   redirect_mem           in   taken branch/jump resolved in MEM
//   load_use_hazard        in   ID instruction needs the load result now in EX
//   halted_controller_mem  in   halt instruction reached MEM
//   pc_lock                out  hold PC
//   lock_if_id..lock_mem_wb out hold the stage buffer
//   flush_if_id..flush_ex_mem out load a NOP into the buffer on the next edge
//   mem_start              out  registered 1-cycle pulse: start the memory fill
//   mem_done               out  combinational: last miss cycle, data valid
//   halted                 out  registered, sticky halt indication
//   stall_cycles, flush_count  out [31:0], only with PIPE_STALL_STATS_EN
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal flow; hazards and redirects are resolved here
// MEM_WAIT  | cache fill in progress; the whole pipe holds until cnt==0
// HALT      | pipe frozen; leaves only through reset
module pipeline_lock_controller #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_access_mem,
  input  logic        cache_hit_mem,
  input  logic        is_nop_mem,
  input  logic        redirect_mem,
  input  logic        load_use_hazard,
  input  logic        halted_controller_mem,
  output logic        pc_lock,
  output logic        lock_if_id,
  output logic        lock_id_ex,
  output logic        lock_ex_mem,
  output logic        lock_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        mem_start,
  output logic        mem_done,
  output logic        halted
`ifdef PIPE_STALL_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_start_d;
  logic             halted_d;
  logic             redirect_acc;
  logic             miss;
  logic             halt_ev;

  assign miss    = mem_access_mem & ~cache_hit_mem & ~is_nop_mem;
  assign halt_ev = halted_controller_mem & ~is_nop_mem;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      mem_start <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_start <= mem_start_d;
      halted    <= halted_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_start_d  = 1'b0;
    halted_d     = halted;
    redirect_acc = 1'b0;
    pc_lock      = 1'b0;
    lock_if_id   = 1'b0;
    lock_id_ex   = 1'b0;
    lock_ex_mem  = 1'b0;
    lock_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    mem_done     = 1'b0;

    // Outputs are forced quiet while reset is held so nothing leaks out of
    // the register being asynchronously cleared.
    if (!rst_b) begin
      unique case (state_q)
        S_RUN: begin
          if (halt_ev) begin
            {pc_lock, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb} = '1;
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else if (miss) begin
            // Miss outranks redirect/load-use: the buffers hold, so those
            // inputs are seen again in the first RUN cycle after the fill.
            {pc_lock, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb} = '1;
            state_d     = S_MEM_WAIT;
            cnt_d       = CNT_LOAD;
            mem_start_d = 1'b1;
          end else if (redirect_mem) begin
            {flush_if_id, flush_id_ex, flush_ex_mem} = '1;
            redirect_acc = 1'b1;
          end else if (load_use_hazard) begin
            // Hold PC and IF/ID, push a bubble into ID/EX; older stages drain.
            pc_lock     = 1'b1;
            lock_if_id  = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (cnt_q != '0) begin
            {pc_lock, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb} = '1;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            mem_done = 1'b1;
            state_d  = S_RUN;
          end
        end
        S_HALT: begin
          {pc_lock, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb} = '1;
          halted_d = 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

`ifdef PIPE_STALL_STATS_EN
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_lock && state_q != S_HALT) stall_cycles <= stall_cycles + 32'd1;
      if (redirect_acc)                 flush_count  <= flush_count + 32'd1;
    end
  end
`else
  logic unused_redirect_acc;
  assign unused_redirect_acc = redirect_acc;
`endif

endmodule

// File: tb/tb_pipeline_lock_controller.sv
module tb_pipeline_lock_controller;

  logic clk = 1'b0;
  logic rst_b, mem_access_mem, cache_hit_mem, is_nop_mem;
  logic redirect_mem, load_use_hazard, halted_controller_mem;

  logic pc_lock, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic mem_start, mem_done, halted;

  logic pc_lock1, lock_if_id1, lock_id_ex1, lock_ex_mem1, lock_mem_wb1;
  logic flush_if_id1, flush_id_ex1, flush_ex_mem1;
  logic mem_start1, mem_done1, halted1;

`ifdef PIPE_STALL_STATS_EN
  logic [31:0] stall_cycles, flush_count, stall_cycles1, flush_count1;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0] locks, locks1;
  logic [2:0] flushes;
  assign locks   = {pc_lock, lock_if_id, lock_id_ex, lock_ex_mem, lock_mem_wb};
  assign locks1  = {pc_lock1, lock_if_id1, lock_id_ex1, lock_ex_mem1, lock_mem_wb1};
  assign flushes = {flush_if_id, flush_id_ex, flush_ex_mem};

  always #5 clk = ~clk;

  pipeline_lock_controller #(.MEM_LATENCY(4), .CNT_W(4)) dut (
    .clk(clk), .rst_b(rst_b),
    .mem_access_mem(mem_access_mem), .cache_hit_mem(cache_hit_mem),
    .is_nop_mem(is_nop_mem), .redirect_mem(redirect_mem),
    .load_use_hazard(load_use_hazard), .halted_controller_mem(halted_controller_mem),
    .pc_lock(pc_lock), .lock_if_id(lock_if_id), .lock_id_ex(lock_id_ex),
    .lock_ex_mem(lock_ex_mem), .lock_mem_wb(lock_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .mem_start(mem_start), .mem_done(mem_done), .halted(halted)
`ifdef PIPE_STALL_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  pipeline_lock_controller #(.MEM_LATENCY(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_b(rst_b),
    .mem_access_mem(mem_access_mem), .cache_hit_mem(cache_hit_mem),
    .is_nop_mem(is_nop_mem), .redirect_mem(redirect_mem),
    .load_use_hazard(load_use_hazard), .halted_controller_mem(halted_controller_mem),
    .pc_lock(pc_lock1), .lock_if_id(lock_if_id1), .lock_id_ex(lock_id_ex1),
    .lock_ex_mem(lock_ex_mem1), .lock_mem_wb(lock_mem_wb1),
    .flush_if_id(flush_if_id1), .flush_id_ex(flush_id_ex1), .flush_ex_mem(flush_ex_mem1),
    .mem_start(mem_start1), .mem_done(mem_done1), .halted(halted1)
`ifdef PIPE_STALL_STATS_EN
    , .stall_cycles(stall_cycles1), .flush_count(flush_count1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_access_mem = 0; cache_hit_mem = 0; is_nop_mem = 0;
    redirect_mem = 0; load_use_hazard = 0; halted_controller_mem = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_b = 1;
    redirect_mem = 1; load_use_hazard = 1;
    #2;
    checks++;
    if (locks !== 5'b0 || flushes !== 3'b0) begin
      errors++;
      $display("FAIL reset_outputs: locks=%b flushes=%b, want 00000/000", locks, flushes);
    end
    checks++;
    if (halted !== 1'b0 || mem_start !== 1'b0 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: halted=%b mem_start=%b mem_done=%b, want 0/0/0",
               halted, mem_start, mem_done);
    end
    idle_inputs();
    step();
    rst_b = 0;
    #1;
    checks++;
    if (locks !== 5'b0 || flushes !== 3'b0 || halted !== 1'b0 || mem_start !== 1'b0) begin
      errors++;
      $display("FAIL idle_run: locks=%b flushes=%b halted=%b mem_start=%b, want all 0",
               locks, flushes, halted, mem_start);
    end
  endtask

  task automatic test_miss();
    step();
    mem_access_mem = 1; cache_hit_mem = 0;
    #1;                                              // cycle t
    checks++;
    if (locks !== 5'b11111 || mem_start !== 1'b0 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL miss_t0: locks=%b mem_start=%b mem_done=%b, want 11111/0/0",
               locks, mem_start, mem_done);
    end
    checks++;
    if (locks1 !== 5'b11111) begin
      errors++;
      $display("FAIL lat1_t0: locks=%b, want 11111", locks1);
    end
    step();
    idle_inputs();
    #1;                                              // t+1
    checks++;
    if (locks !== 5'b11111 || mem_start !== 1'b1 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL miss_t1: locks=%b mem_start=%b mem_done=%b, want 11111/1/0",
               locks, mem_start, mem_done);
    end
    checks++;
    if (locks1 !== 5'b0 || mem_done1 !== 1'b1 || mem_start1 !== 1'b1) begin
      errors++;
      $display("FAIL lat1_t1: locks=%b mem_done=%b mem_start=%b, want 00000/1/1",
               locks1, mem_done1, mem_start1);
    end
    step(); #1;                                      // t+2
    checks++;
    if (locks !== 5'b11111 || mem_start !== 1'b0 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL miss_t2: locks=%b mem_start=%b mem_done=%b, want 11111/0/0",
               locks, mem_start, mem_done);
    end
    checks++;
    if (locks1 !== 5'b0 || mem_done1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_t2: locks=%b mem_done=%b, want 00000/0", locks1, mem_done1);
    end
    step(); #1;                                      // t+3
    checks++;
    if (locks !== 5'b11111 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL miss_t3: locks=%b mem_done=%b, want 11111/0", locks, mem_done);
    end
    step(); #1;                                      // t+4
    checks++;
    if (locks !== 5'b0 || mem_done !== 1'b1 || flushes !== 3'b0) begin
      errors++;
      $display("FAIL miss_t4: locks=%b mem_done=%b flushes=%b, want 00000/1/000",
               locks, mem_done, flushes);
    end
    step(); #1;                                      // t+5
    checks++;
    if (locks !== 5'b0 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL miss_t5: locks=%b mem_done=%b, want 00000/0", locks, mem_done);
    end
  endtask

  task automatic test_load_use();
    step();
    load_use_hazard = 1;
    #1;
    checks++;
    if (locks !== 5'b11000 || flushes !== 3'b010) begin
      errors++;
      $display("FAIL load_use: locks=%b flushes=%b, want 11000/010", locks, flushes);
    end
    step();
    load_use_hazard = 0;
    #1;
    checks++;
    if (locks !== 5'b0 || flushes !== 3'b0) begin
      errors++;
      $display("FAIL load_use_after: locks=%b flushes=%b, want 00000/000", locks, flushes);
    end
  endtask

  task automatic test_redirect_over_load_use();
    step();
    redirect_mem = 1; load_use_hazard = 1;
    #1;
    checks++;
    if (locks !== 5'b0 || flushes !== 3'b111) begin
      errors++;
      $display("FAIL redirect_lu: locks=%b flushes=%b, want 00000/111", locks, flushes);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_miss_with_redirect();
    step();
    mem_access_mem = 1; cache_hit_mem = 0; redirect_mem = 1;
    #1;
    checks++;
    if (locks !== 5'b11111 || flushes !== 3'b0) begin
      errors++;
      $display("FAIL miss_redir_t0: locks=%b flushes=%b, want 11111/000", locks, flushes);
    end
    step();
    cache_hit_mem = 1;                               // fill returns a hit afterwards
    #1;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (locks !== 5'b11111 || flushes !== 3'b0) begin
        errors++;
        $display("FAIL miss_redir_wait%0d: locks=%b flushes=%b, want 11111/000",
                 i, locks, flushes);
      end
      step(); #1;
    end
    checks++;
    if (locks !== 5'b0 || flushes !== 3'b0 || mem_done !== 1'b1) begin
      errors++;
      $display("FAIL miss_redir_fill: locks=%b flushes=%b mem_done=%b, want 00000/000/1",
               locks, flushes, mem_done);
    end
    step(); #1;
    checks++;
    if (locks !== 5'b0 || flushes !== 3'b111) begin
      errors++;
      $display("FAIL miss_redir_after: locks=%b flushes=%b, want 00000/111", locks, flushes);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    step();
    mem_access_mem = 1; cache_hit_mem = 0;
    step();
    idle_inputs();
    step();
    rst_b = 1;
    #1;
    checks++;
    if (locks !== 5'b0 || mem_start !== 1'b0 || mem_done !== 1'b0 || flushes !== 3'b0) begin
      errors++;
      $display("FAIL rst_mid_wait: locks=%b mem_start=%b mem_done=%b flushes=%b, want 0",
               locks, mem_start, mem_done, flushes);
    end
    step();
    rst_b = 0;
    mem_access_mem = 1; cache_hit_mem = 0;
    #1;
    checks++;
    if (locks !== 5'b11111) begin
      errors++;
      $display("FAIL rst_wait_remiss: locks=%b, want 11111", locks);
    end
    step();
    idle_inputs();
    step(); step(); #1;                              // t+3
    checks++;
    if (locks !== 5'b11111 || mem_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_cnt: locks=%b mem_done=%b, want 11111/0", locks, mem_done);
    end
    step(); #1;                                      // t+4
    checks++;
    if (locks !== 5'b0 || mem_done !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_done: locks=%b mem_done=%b, want 00000/1", locks, mem_done);
    end
  endtask

  task automatic test_halt();
    step();
    halted_controller_mem = 1; is_nop_mem = 1;
    #1;
    checks++;
    if (locks !== 5'b0) begin
      errors++;
      $display("FAIL halt_nop: locks=%b, want 00000", locks);
    end
    step();
    is_nop_mem = 0;
    #1;
    checks++;
    if (locks !== 5'b11111 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_detect: locks=%b halted=%b, want 11111/0", locks, halted);
    end
    step();
    idle_inputs();
    redirect_mem = 1; mem_access_mem = 1;
    #1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (locks !== 5'b11111 || flushes !== 3'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold%0d: locks=%b flushes=%b halted=%b, want 11111/000/1",
                 i, locks, flushes, halted);
      end
      step(); #1;
    end
    idle_inputs();
    rst_b = 1;
    #1;
    checks++;
    if (locks !== 5'b0 || flushes !== 3'b0 || halted !== 1'b0 || mem_start !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: locks=%b flushes=%b halted=%b mem_start=%b, want all 0",
               locks, flushes, halted, mem_start);
    end
    step();
    rst_b = 0;
    step(); #1;
    checks++;
    if (locks !== 5'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_exit: locks=%b halted=%b, want 00000/0", locks, halted);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_load_use();
    test_redirect_over_load_use();
    test_miss_with_redirect();
    test_reset_mid_wait();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
